rn_wr_route_fifo: RTL and testbench
===================================

RN_WR_ROUTE_FIFO -- requirements
Module: rn_wr_route_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, max outstanding write bursts; power of two, >=2.
REQ-002 SHALL have parameter ADDR_W, default 32, AW address width.
REQ-003 SHALL have parameter TGT_W, default 2, target node ID width.
REQ-004 SHALL have one clock; reset is asynchronous and active-low; ports named clk and rst.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 s_awvalid / s_awready  input / output  1 / 1  CPU-side AW handshake.
REQ-008 s_awaddr  input  ADDR_W  AW address.
REQ-009 s_awlen  input  8  AW burst length minus one.
REQ-010 n_awvalid / n_awready  output / input  1 / 1  NoC-side AW handshake.
REQ-011 n_awtgtid  output  TGT_W  AW target node.
REQ-012 s_wvalid / s_wready / s_wlast  input / output / input  1 each  CPU-side W handshake and last flag.
REQ-013 n_wvalid / n_wready  output / input  1 / 1  NoC-side W handshake.
REQ-014 n_whead / n_wtail  output  1 / 1  first / last flit of current burst.
REQ-015 n_wtgtid  output  TGT_W  target of current W burst.
REQ-016 occupancy  output  $clog2(DEPTH)+1  outstanding bursts stored.
REQ-017 wlast_err  output  1  one-cycle pulse on WLAST/length mismatch.

Function
REQ-018 n_awtgtid SHALL equal s_awaddr[ADDR_W-1 -: TGT_W], combinational.
REQ-019 n_awvalid = s_awvalid & !full; s_awready = n_awready & !full; full blocks AW even when a pop occurs in the same cycle.
REQ-020 On AW handshake (s_awvalid & s_awready), {n_awtgtid, s_awlen} SHALL be pushed at the write pointer; pointer wraps modulo DEPTH.
REQ-021 n_wvalid = s_wvalid & !empty; s_wready = n_wready & !empty; no AW-to-W bypass: an entry is usable the cycle after its push.
REQ-022 n_wtgtid SHALL equal the head entry target whenever non-empty; 0 when empty.
REQ-023 A beat counter (8 bits) SHALL count accepted W beats of the head burst; n_whead = (count==0) & !empty; n_wtail = (count==head len) & !empty.
REQ-024 On an accepted beat with n_wtail=1: head entry popped, count cleared; otherwise count increments.
REQ-025 Tail timing SHALL follow stored length, not s_wlast.
REQ-026 wlast_err SHALL pulse high the cycle after any accepted beat where s_wlast != n_wtail.
REQ-027 Simultaneous push and pop (not full) SHALL leave occupancy unchanged; push-only +1; pop-only -1.
REQ-028 Single-beat burst (len 0): n_whead and n_wtail both high on the same beat.

Reset
REQ-029 While rst low: pointers, count, occupancy 0; wlast_err 0; empty=1, so n_wvalid, s_wready, n_whead, n_wtail, n_wtgtid = 0.
REQ-030 Reset mid-burst SHALL discard all entries and partial-burst state; first AW after release starts a fresh burst.

Structure
REQ-031 Shared package rn_pkg SHALL hold default TGT_W/ADDR_W constants and the entry struct type {tgtid, len}.
REQ-032 Storage SHALL be one sub-module rn_sync_fifo (parametrised width/depth, full/empty/count); beat counter and flag logic live in the top.

Verification
REQ-033 AW addr 0x8000_0000 len 3, then 4 W beats with WLAST on 4th -> n_wtgtid=2 all beats, head on beat 1, tail on beat 4, occupancy 1->0, no wlast_err.
REQ-034 DEPTH=4: five AWs, no W -> 5th stalls (s_awready=0, occupancy 4); one tail popped -> 5th accepted the following cycle.
REQ-035 W presented before any AW -> s_wready=0, n_wvalid=0; AW push at cycle N -> W accepted earliest cycle N+1.
REQ-036 len 0 bursts to targets 1,3 back-to-back -> each beat head=tail=1, n_wtgtid 1 then 3.
REQ-037 len 1 burst, WLAST asserted on beat 1 -> n_wtail on beat 2 only, wlast_err pulses after beat 1 and after beat 2.
REQ-038 rst asserted after 2 of 4 beats -> occupancy 0 immediately; new AW len 0 -> next beat has head=tail=1.

Source files
------------

// File: rtl/rn_pkg.sv
// ----------------------------------------------------------------------------
// rn_pkg
// Shared definitions for the write-routing FIFO.
//   RN_ADDR_W / RN_TGT_W : default AW address and target-ID widths
//   RN_LEN_W             : AXI burst length field width (AxLEN)
//   rn_entry_t           : one stored burst descriptor {tgtid, len}; the
//                          FIFO word layout used by rn_wr_route_fifo matches
//                          this struct bit-for-bit at the default widths
//   rn_cnt_w()           : width of an occupancy count for a given depth
// ----------------------------------------------------------------------------
package rn_pkg;

    localparam int RN_ADDR_W = 32;
    localparam int RN_TGT_W  = 2;
    localparam int RN_LEN_W  = 8;

    typedef struct packed {
        logic [RN_TGT_W-1:0] tgtid;
        logic [RN_LEN_W-1:0] len;
    } rn_entry_t;

    // A count must be able to hold the value DEPTH itself, hence the +1.
    function automatic int rn_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rn_sync_fifo.sv
// ----------------------------------------------------------------------------
// rn_sync_fifo
// Single-clock FIFO with a combinational head read (first-word fall-through),
// so the entry at the read pointer is visible the cycle after it is pushed.
//   clk          rising-edge clock
//   rst          asynchronous active-low reset (pointers and count only)
//   push_i       write request, ignored while full
//   push_data_i  word to write
//   pop_i        read/advance request, ignored while empty
//   head_o       word at the read pointer (undefined while empty)
//   full_o       DEPTH words stored
//   empty_o      no words stored
//   count_o      number of words stored (0..DEPTH)
// ----------------------------------------------------------------------------
module rn_sync_fifo
    import rn_pkg::*;
#(
    parameter int WIDTH = RN_TGT_W + RN_LEN_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic do_push;
    logic do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i  & ~empty_o;

    // DEPTH is a power of two, so plain pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: stale words are never observable because the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/rn_wr_route_fifo.sv
// ----------------------------------------------------------------------------
// rn_wr_route_fifo
// Routes AXI write bursts onto a NoC. Each accepted AW records its target
// node (top address bits) and burst length; the W channel then streams the
// head burst, tagging every flit with its target plus head/tail markers.
// Burst boundaries come from the stored length, not from WLAST; a WLAST that
// disagrees with the stored length raises a one-cycle wlast_err.
//   clk, rst                       clock, asynchronous active-low reset
//   s_awvalid/s_awready            CPU-side AW handshake
//   s_awaddr, s_awlen              AW address, burst length minus one
//   n_awvalid/n_awready, n_awtgtid NoC-side AW handshake and target
//   s_wvalid/s_wready, s_wlast     CPU-side W handshake and last flag
//   n_wvalid/n_wready              NoC-side W handshake
//   n_whead, n_wtail, n_wtgtid     first/last flit marker, burst target
//   occupancy                      bursts stored
//   wlast_err                      WLAST/length mismatch pulse
// ----------------------------------------------------------------------------
module rn_wr_route_fifo
    import rn_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = RN_ADDR_W,
    parameter int TGT_W  = RN_TGT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    // CPU-side AW
    input  logic                   s_awvalid,
    output logic                   s_awready,
    input  logic [ADDR_W-1:0]      s_awaddr,
    input  logic [7:0]             s_awlen,
    // NoC-side AW
    output logic                   n_awvalid,
    input  logic                   n_awready,
    output logic [TGT_W-1:0]       n_awtgtid,
    // CPU-side W
    input  logic                   s_wvalid,
    output logic                   s_wready,
    input  logic                   s_wlast,
    // NoC-side W
    output logic                   n_wvalid,
    input  logic                   n_wready,
    output logic                   n_whead,
    output logic                   n_wtail,
    output logic [TGT_W-1:0]       n_wtgtid,
    // Status
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   wlast_err
);

    // Word layout {tgtid, len}, identical to rn_entry_t at default widths.
    localparam int ENTRY_W = TGT_W + RN_LEN_W;

    logic               full;
    logic               empty;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head_data;
    logic [TGT_W-1:0]   head_tgt;
    logic [RN_LEN_W-1:0] head_len;

    logic aw_hs;
    logic w_hs;
    logic pop;

    logic [RN_LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic                wlast_err_q, wlast_err_d;

    // Only the target bits of the address are routed; the rest is consumed
    // here so it does not show up as dangling logic.
    logic unused_addr_bits;
    generate
        if (ADDR_W > TGT_W) begin : g_addr_rest
            assign unused_addr_bits = ^s_awaddr[ADDR_W-TGT_W-1:0];
        end else begin : g_addr_none
            assign unused_addr_bits = 1'b0;
        end
    endgenerate

    // ---------------- AW side ----------------
    assign n_awtgtid = s_awaddr[ADDR_W-1 -: TGT_W];
    // Full blocks AW even if the head pops this cycle: the pop frees a slot
    // only from the next cycle on, which keeps the ready path short.
    assign n_awvalid = s_awvalid & ~full;
    assign s_awready = n_awready & ~full;
    assign aw_hs     = s_awvalid & s_awready;
    assign push_data = {n_awtgtid, s_awlen};

    // ---------------- Burst store ----------------
    rn_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (aw_hs),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head_data),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (occupancy)
    );

    assign head_tgt = head_data[ENTRY_W-1 -: TGT_W];
    assign head_len = head_data[RN_LEN_W-1:0];

    // ---------------- W side ----------------
    // W depends only on the stored FIFO state, never on this cycle's AW, so
    // a freshly pushed burst becomes usable one cycle after its handshake.
    assign n_wvalid = s_wvalid & ~empty;
    assign s_wready = n_wready & ~empty;
    assign w_hs     = s_wvalid & s_wready;

    assign n_whead  = (beat_cnt_q == '0)       & ~empty;
    assign n_wtail  = (beat_cnt_q == head_len) & ~empty;
    assign n_wtgtid = empty ? '0 : head_tgt;

    assign pop = w_hs & n_wtail;

    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        wlast_err_d = 1'b0;
        if (w_hs) begin
            beat_cnt_d  = n_wtail ? '0 : beat_cnt_q + RN_LEN_W'(1);
            wlast_err_d = (s_wlast != n_wtail);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt_q  <= '0;
            wlast_err_q <= 1'b0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            wlast_err_q <= wlast_err_d;
        end
    end

    assign wlast_err = wlast_err_q;

endmodule

// File: tb/tb_rn_wr_route_fifo.sv
// ----------------------------------------------------------------------------
// tb_rn_wr_route_fifo
// Directed scenarios for rn_wr_route_fifo at DEPTH=4, ADDR_W=32, TGT_W=2.
// Inputs change 1 ns after a rising edge; combinational outputs are checked
// on the falling edge, registered outputs 1 ns after the rising edge.
// ----------------------------------------------------------------------------
module tb_rn_wr_route_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_awvalid, s_awready;
    logic [31:0] s_awaddr;
    logic [7:0]  s_awlen;
    logic        n_awvalid, n_awready;
    logic [1:0]  n_awtgtid;
    logic        s_wvalid, s_wready, s_wlast;
    logic        n_wvalid, n_wready;
    logic        n_whead, n_wtail;
    logic [1:0]  n_wtgtid;
    logic [2:0]  occupancy;
    logic        wlast_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rn_wr_route_fifo #(
        .DEPTH  (4),
        .ADDR_W (32),
        .TGT_W  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_awaddr  (s_awaddr),
        .s_awlen   (s_awlen),
        .n_awvalid (n_awvalid),
        .n_awready (n_awready),
        .n_awtgtid (n_awtgtid),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_wlast   (s_wlast),
        .n_wvalid  (n_wvalid),
        .n_wready  (n_wready),
        .n_whead   (n_whead),
        .n_wtail   (n_wtail),
        .n_wtgtid  (n_wtgtid),
        .occupancy (occupancy),
        .wlast_err (wlast_err)
    );

    task automatic idle();
        s_awvalid = 1'b0;
        s_awaddr  = '0;
        s_awlen   = '0;
        s_wvalid  = 1'b0;
        s_wlast   = 1'b0;
        n_awready = 1'b1;
        n_wready  = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        idle();
        s_wvalid = 1'b1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL rst_occupancy got %0d want 0", occupancy); end
        n_cmp++; if (n_wvalid !== 1'b0) begin n_err++; $display("FAIL rst_n_wvalid got %b want 0", n_wvalid); end
        n_cmp++; if (s_wready !== 1'b0) begin n_err++; $display("FAIL rst_s_wready got %b want 0", s_wready); end
        n_cmp++; if (n_whead !== 1'b0) begin n_err++; $display("FAIL rst_n_whead got %b want 0", n_whead); end
        n_cmp++; if (n_wtail !== 1'b0) begin n_err++; $display("FAIL rst_n_wtail got %b want 0", n_wtail); end
        n_cmp++; if (n_wtgtid !== 2'd0) begin n_err++; $display("FAIL rst_n_wtgtid got %0d want 0", n_wtgtid); end
        n_cmp++; if (wlast_err !== 1'b0) begin n_err++; $display("FAIL rst_wlast_err got %b want 0", wlast_err); end
        step();
        rst = 1'b1;
        s_wvalid = 1'b0;
        $display("reset released");
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_burst();
        idle();
        s_awvalid = 1'b1;
        s_awaddr  = 32'h8000_0000;
        s_awlen   = 8'd3;
        @(negedge clk);
        n_cmp++; if (n_awtgtid !== 2'd2) begin n_err++; $display("FAIL sb_n_awtgtid got %0d want 2", n_awtgtid); end
        n_cmp++; if (n_awvalid !== 1'b1) begin n_err++; $display("FAIL sb_n_awvalid got %b want 1", n_awvalid); end
        n_cmp++; if (s_awready !== 1'b1) begin n_err++; $display("FAIL sb_s_awready got %b want 1", s_awready); end
        step();
        $display("AW addr=%h len=3", s_awaddr);
        s_awvalid = 1'b0;
        n_cmp++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL sb_occ_after_aw got %0d want 1", occupancy); end
        for (int i = 0; i < 4; i++) begin
            s_wvalid = 1'b1;
            s_wlast  = (i == 3);
            @(negedge clk);
            n_cmp++; if (n_wtgtid !== 2'd2) begin n_err++; $display("FAIL sb_n_wtgtid beat%0d got %0d want 2", i, n_wtgtid); end
            n_cmp++; if (n_whead !== (i == 0)) begin n_err++; $display("FAIL sb_n_whead beat%0d got %b want %b", i, n_whead, (i == 0)); end
            n_cmp++; if (n_wtail !== (i == 3)) begin n_err++; $display("FAIL sb_n_wtail beat%0d got %b want %b", i, n_wtail, (i == 3)); end
            n_cmp++; if (n_wvalid !== 1'b1) begin n_err++; $display("FAIL sb_n_wvalid beat%0d got %b want 1", i, n_wvalid); end
            n_cmp++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL sb_occ beat%0d got %0d want 1", i, occupancy); end
            step();
            $display("W beat=%0d tgt=2 last=%b", i, s_wlast);
            n_cmp++; if (wlast_err !== 1'b0) begin n_err++; $display("FAIL sb_wlast_err beat%0d got %b want 0", i, wlast_err); end
        end
        idle();
        n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL sb_occ_end got %0d want 0", occupancy); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_full();
        idle();
        for (int i = 0; i < 5; i++) begin
            s_awvalid = 1'b1;
            s_awaddr  = {i[1:0], 30'd0};
            s_awlen   = 8'd0;
            @(negedge clk);
            n_cmp++; if (s_awready !== (i < 4)) begin n_err++; $display("FAIL full_s_awready aw%0d got %b want %b", i, s_awready, (i < 4)); end
            n_cmp++; if (occupancy !== 3'((i < 4) ? i : 4)) begin n_err++; $display("FAIL full_occ aw%0d got %0d want %0d", i, occupancy, (i < 4) ? i : 4); end
            step();
            $display("AW try=%0d tgt=%0d", i, i % 4);
        end
        n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL full_occ_stall got %0d want 4", occupancy); end
        // Pop one tail while the 5th AW is still waiting.
        s_wvalid = 1'b1;
        s_wlast  = 1'b1;
        @(negedge clk);
        n_cmp++; if (n_wtail !== 1'b1) begin n_err++; $display("FAIL full_pop_tail got %b want 1", n_wtail); end
        n_cmp++; if (n_wtgtid !== 2'd0) begin n_err++; $display("FAIL full_pop_tgt got %0d want 0", n_wtgtid); end
        n_cmp++; if (s_awready !== 1'b0) begin n_err++; $display("FAIL full_awready_on_pop got %b want 0", s_awready); end
        n_cmp++; if (n_awvalid !== 1'b0) begin n_err++; $display("FAIL full_awvalid_on_pop got %b want 0", n_awvalid); end
        step();
        $display("W pop tgt=0");
        s_wvalid = 1'b0;
        s_wlast  = 1'b0;
        n_cmp++; if (occupancy !== 3'd3) begin n_err++; $display("FAIL full_occ_after_pop got %0d want 3", occupancy); end
        @(negedge clk);
        n_cmp++; if (s_awready !== 1'b1) begin n_err++; $display("FAIL full_awready_after_pop got %b want 1", s_awready); end
        step();
        $display("AW 5th accepted");
        s_awvalid = 1'b0;
        n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL full_occ_refill got %0d want 4", occupancy); end
        for (int j = 0; j < 4; j++) begin
            s_wvalid = 1'b1;
            s_wlast  = 1'b1;
            @(negedge clk);
            n_cmp++; if (n_wtgtid !== 2'((j + 1) % 4)) begin n_err++; $display("FAIL full_drain_tgt %0d got %0d want %0d", j, n_wtgtid, (j + 1) % 4); end
            n_cmp++; if ({n_whead, n_wtail} !== 2'b11) begin n_err++; $display("FAIL full_drain_headtail %0d got %b%b want 11", j, n_whead, n_wtail); end
            step();
            $display("W drain=%0d", j);
        end
        idle();
        n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL full_occ_end got %0d want 0", occupancy); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_no_bypass();
        idle();
        s_wvalid = 1'b1;
        s_wlast  = 1'b1;
        @(negedge clk);
        n_cmp++; if (s_wready !== 1'b0) begin n_err++; $display("FAIL nb_s_wready_empty got %b want 0", s_wready); end
        n_cmp++; if (n_wvalid !== 1'b0) begin n_err++; $display("FAIL nb_n_wvalid_empty got %b want 0", n_wvalid); end
        step();
        s_awvalid = 1'b1;
        s_awaddr  = 32'hC000_0000;
        s_awlen   = 8'd0;
        @(negedge clk);
        n_cmp++; if (s_wready !== 1'b0) begin n_err++; $display("FAIL nb_s_wready_push_cycle got %b want 0", s_wready); end
        n_cmp++; if (n_wvalid !== 1'b0) begin n_err++; $display("FAIL nb_n_wvalid_push_cycle got %b want 0", n_wvalid); end
        step();
        $display("AW tgt=3 len=0 (W waiting)");
        s_awvalid = 1'b0;
        @(negedge clk);
        n_cmp++; if (s_wready !== 1'b1) begin n_err++; $display("FAIL nb_s_wready_next got %b want 1", s_wready); end
        n_cmp++; if (n_wtgtid !== 2'd3) begin n_err++; $display("FAIL nb_n_wtgtid got %0d want 3", n_wtgtid); end
        n_cmp++; if ({n_whead, n_wtail} !== 2'b11) begin n_err++; $display("FAIL nb_headtail got %b%b want 11", n_whead, n_wtail); end
        step();
        $display("W beat tgt=3");
        idle();
        n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL nb_occ_end got %0d want 0", occupancy); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        idle();
        s_awvalid = 1'b1;
        s_awaddr  = 32'h4000_0000;
        s_awlen   = 8'd0;
        step();
        $display("AW tgt=1 len=0");
        s_awaddr = 32'hC000_0000;
        s_wvalid = 1'b1;
        s_wlast  = 1'b1;
        @(negedge clk);
        n_cmp++; if (n_wtgtid !== 2'd1) begin n_err++; $display("FAIL b2b_tgt1 got %0d want 1", n_wtgtid); end
        n_cmp++; if ({n_whead, n_wtail} !== 2'b11) begin n_err++; $display("FAIL b2b_headtail1 got %b%b want 11", n_whead, n_wtail); end
        step();
        $display("AW tgt=3 len=0 + W beat tgt=1");
        s_awvalid = 1'b0;
        @(negedge clk);
        n_cmp++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL b2b_occ_pushpop got %0d want 1", occupancy); end
        n_cmp++; if (n_wtgtid !== 2'd3) begin n_err++; $display("FAIL b2b_tgt3 got %0d want 3", n_wtgtid); end
        n_cmp++; if ({n_whead, n_wtail} !== 2'b11) begin n_err++; $display("FAIL b2b_headtail3 got %b%b want 11", n_whead, n_wtail); end
        step();
        $display("W beat tgt=3");
        idle();
        n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL b2b_occ_end got %0d want 0", occupancy); end
        n_cmp++; if (wlast_err !== 1'b0) begin n_err++; $display("FAIL b2b_wlast_err got %b want 0", wlast_err); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_wlast_err();
        idle();
        s_awvalid = 1'b1;
        s_awaddr  = 32'h0000_0000;
        s_awlen   = 8'd1;
        step();
        $display("AW tgt=0 len=1");
        s_awvalid = 1'b0;
        s_wvalid  = 1'b1;
        s_wlast   = 1'b1;
        @(negedge clk);
        n_cmp++; if ({n_whead, n_wtail} !== 2'b10) begin n_err++; $display("FAIL we_beat1_headtail got %b%b want 10", n_whead, n_wtail); end
        step();
        $display("W beat=0 last=1 (early)");
        n_cmp++; if (wlast_err !== 1'b1) begin n_err++; $display("FAIL we_err_after_beat1 got %b want 1", wlast_err); end
        s_wlast = 1'b0;
        @(negedge clk);
        n_cmp++; if ({n_whead, n_wtail} !== 2'b01) begin n_err++; $display("FAIL we_beat2_headtail got %b%b want 01", n_whead, n_wtail); end
        step();
        $display("W beat=1 last=0 (missing)");
        n_cmp++; if (wlast_err !== 1'b1) begin n_err++; $display("FAIL we_err_after_beat2 got %b want 1", wlast_err); end
        idle();
        step();
        n_cmp++; if (wlast_err !== 1'b0) begin n_err++; $display("FAIL we_err_cleared got %b want 0", wlast_err); end
        n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL we_occ_end got %0d want 0", occupancy); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_burst();
        idle();
        s_awvalid = 1'b1;
        s_awaddr  = 32'h8000_0000;
        s_awlen   = 8'd3;
        step();
        $display("AW tgt=2 len=3");
        s_awvalid = 1'b0;
        s_wvalid  = 1'b1;
        s_wlast   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            $display("W beat=%0d before reset", i);
        end
        rst = 1'b0;
        #1;
        n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL rm_occ_async got %0d want 0", occupancy); end
        n_cmp++; if (n_wvalid !== 1'b0) begin n_err++; $display("FAIL rm_n_wvalid got %b want 0", n_wvalid); end
        n_cmp++; if (n_whead !== 1'b0) begin n_err++; $display("FAIL rm_n_whead got %b want 0", n_whead); end
        step();
        step();
        rst = 1'b1;
        idle();
        $display("reset released mid-burst");
        s_awvalid = 1'b1;
        s_awaddr  = 32'h4000_0000;
        s_awlen   = 8'd0;
        step();
        $display("AW tgt=1 len=0");
        s_awvalid = 1'b0;
        s_wvalid  = 1'b1;
        s_wlast   = 1'b1;
        @(negedge clk);
        n_cmp++; if ({n_whead, n_wtail} !== 2'b11) begin n_err++; $display("FAIL rm_headtail got %b%b want 11", n_whead, n_wtail); end
        n_cmp++; if (n_wtgtid !== 2'd1) begin n_err++; $display("FAIL rm_tgt got %0d want 1", n_wtgtid); end
        step();
        $display("W beat tgt=1");
        idle();
        n_cmp++; if (wlast_err !== 1'b0) begin n_err++; $display("FAIL rm_wlast_err got %b want 0", wlast_err); end
        n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL rm_occ_end got %0d want 0", occupancy); end
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_single_burst();
        test_full();
        test_no_bypass();
        test_back_to_back();
        test_wlast_err();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "simulation did not finish");
    end

endmodule
